prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program writer for the 8-bit accumulator processor. It receives a framed byte stream over a valid/ready input and writes the payload into the processor's 16-bit-addressed byte memory.
- It holds the processor in reset (cpu_hold) until an end frame with a valid checksum arrives, then releases it so the processor starts at its fetch state.
- It sits between the external byte source (host link) and the memory write port, muxed ahead of the processor's memory write path.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1024, max idle cycles between bytes inside a frame before error; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- mem_addr  output  16  memory write address.
- mem_wdata  output  8  memory write data.
- mem_we  output  1  one-cycle write strobe.
- cpu_hold  output  1  1 = processor held in reset.
- done  output  1  load completed successfully (sticky).
- err  output  1  load failed (sticky until reset).

Behaviour:
- Frame format: SYNC_BYTE, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CSUM.
- Checksum rule: CSUM = 8-bit (mod 256) sum of ADDR_H through the last payload byte. SYNC_BYTE and CSUM are excluded.
- A frame with LEN = 0 is the end frame.
- Reset (reset = 0, asynchronous):
  - state = S_SYNC.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 1, done = 0, err = 0.
  - Checksum accumulator, byte counter and idle counter = 0.
- Reset mid-frame discards all partial state. Memory writes already issued are not undone.
- in_ready = 1 in every state except S_DONE and S_ERR. It is a combinational decode of state only.
- States and transitions (advance only on a transfer unless noted):
  - S_SYNC: byte == SYNC_BYTE -> S_ADDRH, checksum cleared. Any other byte is silently dropped; stay in S_SYNC. The idle timeout is not active here.
  - S_ADDRH: latch addr[15:8], add byte to checksum -> S_ADDRL.
  - S_ADDRL: latch addr[7:0], add byte to checksum -> S_LENH.
  - S_LENH: latch len[15:8], add byte to checksum -> S_LENL.
  - S_LENL: latch len[7:0], add byte to checksum. Go to S_CSUM if {len_h, byte} == 0, else to S_DATA with count = length.
  - S_DATA: on each transfer, the next cycle has mem_we = 1, mem_addr = current addr, mem_wdata = byte. Then addr increments, count decrements, byte is added to checksum. Leave for S_CSUM when count reaches 0 after the last byte.
  - S_CSUM, byte == accumulator: go to S_DONE if the frame was an end frame, else back to S_SYNC.
  - S_CSUM, byte != accumulator: go to S_ERR.
  - S_DONE: cpu_hold = 0 and done = 1, registered and asserted on the first cycle in S_DONE. Terminal until reset.
  - S_ERR: err = 1, cpu_hold stays 1. Terminal until reset.
- Write latency: exactly 1 cycle from the accepting clock edge to mem_we high. mem_we is never high for 2 consecutive cycles unless 2 payload bytes were accepted back-to-back. Back-to-back acceptance at 1 byte/cycle is required.
- mem_addr and mem_wdata hold their last values while mem_we = 0.
- Address wrap: 16'hFFFF + 1 -> 16'h0000, silently, within a frame.
- Length counter is 16 bits, so up to 65535 payload bytes per frame.
- Multiple data frames may precede the end frame. Later writes to the same address overwrite earlier ones.
- Timeout (TIMEOUT != 0):
  - The idle counter runs in S_ADDRH through S_CSUM and clears on every transfer.
  - When it reaches TIMEOUT with no transfer, go to S_ERR.
  - A transfer in that same cycle wins: no error, counter clears.
- in_valid while in_ready = 0 (S_DONE/S_ERR) is ignored; no state change.

Test Plan:
- Single byte: frame A5 01 00 00 01 3C csum=3E, then end frame A5 00 00 00 00 00 -> one mem_we pulse with addr=0x0100, data=0x3C, 1 cycle after the 3C transfer. Then cpu_hold falls and done=1.
- Burst and wrap: A5 FF FE 00 03 11 22 33 csum, streamed at 1 byte/cycle -> 3 consecutive mem_we cycles with addr FFFE/FFFF/0000 and data 11/22/33.
- Bad checksum: A5 00 10 00 01 55 csum=00 (correct is 0x66) -> S_ERR, err=1, cpu_hold=1, in_ready=0. The single write to 0x0010 still occurred. Further bytes are ignored.
- Garbage before sync: bytes 00 FF 5A, then a valid end frame -> the garbage is dropped with no writes, and done=1.
- Timeout: TIMEOUT=8; send A5 00, then hold in_valid=0 for 8 cycles -> err=1 at the 8th idle cycle. With a 7-cycle gap instead, loading continues normally.
- Async reset: assert reset mid-payload -> all outputs go to reset values immediately. A full new load afterwards succeeds.

Source files
------------

// File: rtl/prog_loader_if.sv
// Stream-in / memory-write-out bundle for the boot-time program loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes the payload into
// the processor's byte memory and releases the processor after a good end frame.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus
);

  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_SYNC, S_ADDRH, S_ADDRL, S_LENH, S_LENL, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e            state_q;
  logic [15:0]       addr_q, count_q, mem_addr_q;
  logic [7:0]        len_h_q, csum_q, mem_wdata_q;
  logic              end_q, mem_we_q, cpu_hold_q, done_q, err_q;
  logic [IDLE_W-1:0] idle_q;
  logic              in_ready, xfer, timed;

  // in_ready decodes state only, so there is no combinational path from in_valid.
  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer     = bus.in_valid && in_ready;
  assign timed    = state_q inside {S_ADDRH, S_ADDRL, S_LENH, S_LENL, S_DATA, S_CSUM};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_SYNC;
      addr_q      <= '0;
      count_q     <= '0;
      len_h_q     <= '0;
      csum_q      <= '0;
      end_q       <= 1'b0;
      idle_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking default makes mem_we a one-cycle strobe; the S_DATA branch overrides it.
      mem_we_q <= 1'b0;
      if (xfer) idle_q <= '0;

      case (state_q)
        S_SYNC: if (xfer && bus.in_data == SYNC_BYTE) begin
          csum_q  <= '0;
          state_q <= S_ADDRH;
        end
        S_ADDRH: if (xfer) begin
          addr_q[15:8] <= bus.in_data;
          csum_q       <= csum_q + bus.in_data;
          state_q      <= S_ADDRL;
        end
        S_ADDRL: if (xfer) begin
          addr_q[7:0] <= bus.in_data;
          csum_q      <= csum_q + bus.in_data;
          state_q     <= S_LENH;
        end
        S_LENH: if (xfer) begin
          len_h_q <= bus.in_data;
          csum_q  <= csum_q + bus.in_data;
          state_q <= S_LENL;
        end
        S_LENL: if (xfer) begin
          csum_q  <= csum_q + bus.in_data;
          count_q <= {len_h_q, bus.in_data};
          end_q   <= ({len_h_q, bus.in_data} == 16'd0);
          state_q <= ({len_h_q, bus.in_data} == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (xfer) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= bus.in_data;
          addr_q      <= addr_q + 16'd1;
          count_q     <= count_q - 16'd1;
          csum_q      <= csum_q + bus.in_data;
          if (count_q == 16'd1) state_q <= S_CSUM;
        end
        S_CSUM: if (xfer) begin
          if (bus.in_data != csum_q) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else if (end_q) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q <= S_SYNC;
          end
        end
        default: ;
      endcase

      // A transfer in the expiring cycle wins; only an idle cycle can time out.
      if (timed && !xfer && TIMEOUT != 0) begin
        if (idle_q == IDLE_LAST) begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are built from the framing rules, expected
// writes are queued as payload bytes are accepted, and a monitor checks every write.
module tb_prog_loader;
  localparam int         TMO  = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  prog_loader_if bus();

  prog_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  bit   exp_err, exp_done;
  logic [15:0] last_addr;
  logic [7:0]  last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard; otherwise outputs hold.
  always @(negedge clk) begin
    if (!reset) begin
      last_addr = '0;
      last_data = '0;
    end else if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
        check("wr_latency_cycle", cyc, mon_e.cyc);
      end
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
    end else begin
      check("hold_addr", 32'(bus.mem_addr), 32'(last_addr));
      check("hold_data", 32'(bus.mem_wdata), 32'(last_data));
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 1);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; idles for gap edges, then offers b for one edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    bit rdy;
    bus.in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    check("err_flag", 32'(bus.err), 32'(exp_err));
    check("in_ready", 32'(bus.in_ready), 32'(!(exp_err || exp_done)));
    rdy = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    acc = rdy;
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Sends SYNC, header, payload, checksum (xor cmask). lg_at/lg_len force one long gap;
  // stop_at >= 0 truncates the frame after that many bytes.
  task automatic send_frame(input logic [15:0] a, input logic [7:0] pl[$], input logic [7:0] cmask,
                            input int gap_hi, input int lg_at, input int lg_len, input int stop_at);
    logic [7:0] bytes[$];
    logic [7:0] sum;
    int         n, gap, last;
    bit         acc;
    n = pl.size();
    bytes = {a[15:8], a[7:0], 8'(n >> 8), 8'(n)};
    foreach (pl[i]) bytes.push_back(pl[i]);
    sum = '0;
    foreach (bytes[i]) sum = sum + bytes[i];
    bytes.push_front(SYNC);
    bytes.push_back(sum ^ cmask);
    last = (stop_at >= 0) ? stop_at : bytes.size();
    for (int i = 0; i < last; i++) begin
      gap = (i == lg_at) ? lg_len : $urandom_range(0, gap_hi);
      if (i > 0 && gap >= TMO && !exp_err && !exp_done) exp_err = 1'b1;
      send_byte(bytes[i], gap, acc);
      if (acc && i >= 5 && i < 5 + n)
        exp_q.push_back('{addr: a + 16'(i - 5), data: bytes[i], cyc: cyc});
      if (acc && i == 5 + n) begin
        if (cmask != 8'h00) exp_err = 1'b1;
        else if (n == 0) exp_done = 1'b1;
        check("csum_err", 32'(bus.err), 32'(exp_err));
        check("csum_done", 32'(bus.done), 32'(exp_done));
        check("csum_cpu_hold", 32'(bus.cpu_hold), 32'(!exp_done));
      end
    end
  endtask

  task automatic end_checks(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(!(exp_done || exp_err)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  empty[$];
    logic [15:0] a;
    bit          acc;
    int          n, nfr, lg_at, lg_len;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Single byte write followed by the end frame.
    do_reset();
    send_frame(16'h0100, '{8'h3C}, 8'h00, 0, -1, 0, -1);
    send_frame(16'h0000, empty, 8'h00, 0, -1, 0, -1);
    end_checks("single");

    // Back-to-back burst crossing the top of the address space.
    do_reset();
    send_frame(16'hFFFE, '{8'h11, 8'h22, 8'h33}, 8'h00, 0, -1, 0, -1);
    send_frame(16'h0000, empty, 8'h00, 0, -1, 0, -1);
    end_checks("wrap");

    // Bad checksum (00 instead of 66): write still happens, then later bytes are refused.
    do_reset();
    send_frame(16'h0010, '{8'h55}, 8'h66, 0, -1, 0, -1);
    for (int i = 0; i < 4; i++) send_byte(8'(SYNC + i), 0, acc);
    end_checks("badcsum");

    // Garbage ahead of the sync byte is dropped.
    do_reset();
    send_byte(8'h00, 2, acc);
    send_byte(8'hFF, 0, acc);
    send_byte(8'h5A, 20, acc);
    send_frame(16'h0000, empty, 8'h00, 0, -1, 0, -1);
    end_checks("garbage");

    // Idle gap of TMO cycles after ADDR_H times out; TMO-1 does not.
    do_reset();
    send_frame(16'h0042, '{8'h99}, 8'h00, 0, 2, TMO, -1);
    end_checks("timeout");
    do_reset();
    send_frame(16'h0042, '{8'h99}, 8'h00, 0, 2, TMO - 1, -1);
    send_frame(16'h1234, empty, 8'h00, TMO - 1, -1, 0, -1);
    end_checks("nearmiss");

    // Asynchronous reset in the middle of a payload, then a full load.
    do_reset();
    send_frame(16'h2000, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 8'h00, 1, -1, 0, 7);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals();
    do_reset();
    send_frame(16'h2000, '{8'hA1, 8'hB2}, 8'h00, 1, -1, 0, -1);
    send_frame(16'h0000, empty, 8'h00, 1, -1, 0, -1);
    end_checks("midreset");

    // Randomized loads: several data frames, occasional corruption or long gaps.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send_byte(g, $urandom_range(0, 12), acc);
      end
      nfr = $urandom_range(1, 3);
      for (int f = 0; f <= nfr; f++) begin
        n = (f == nfr) ? 0 : $urandom_range(1, 16);
        pl.delete();
        repeat (n) pl.push_back(8'($urandom));
        a = $urandom_range(0, 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
        lg_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5 + n) : -1;
        lg_len = $urandom_range(TMO - 1, TMO);
        send_frame(a, pl, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                   (it % 2 == 0) ? 0 : 3, lg_at, lg_len, -1);
      end
      end_checks("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
